// File: rtl/mmaps_pkg.sv
// mmaps_pkg -- constants and types shared by the ring-buffer write path.
//   SIZE_DEFAULT : default ring address width (depth 2**SIZE_DEFAULT)
//   ring_state_t : write controller state encoding
package mmaps_pkg;
  localparam int SIZE_DEFAULT = 12;

  typedef enum logic [2:0] {
    ST_FILL    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_POST    = 3'd2,
    ST_READOUT = 3'd3,
    ST_REARM   = 3'd4
  } ring_state_t;
endpackage

// File: rtl/trig_edge.sv
// trig_edge -- rising-edge detector for the trigger level input.
// Build option: define RING_TRIG_SYNC_EN to insert a 2-flop synchronizer
// ahead of the detector (asynchronous trigger source, +2 cycles latency).
// Ports:
//   sysclk : system clock (rising edge)
//   rst_n  : asynchronous active-low reset
//   trig_i : trigger level
//   rise   : one-cycle pulse, combinational from the detector input
module trig_edge (
  input  logic sysclk,
  input  logic rst_n,
  input  logic trig_i,
  output logic rise
);
  logic trig_s;
  logic trig_q;

`ifdef RING_TRIG_SYNC_EN
  logic [1:0] sync;
  // Reset high so a trigger held high through reset is not seen as an edge.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], trig_i};
  end
  assign trig_s = sync[1];
`else
  assign trig_s = trig_i;
`endif

  // History resets to 1: a level already high is never an edge.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) trig_q <= 1'b1;
    else        trig_q <= trig_s;
  end

  assign rise = trig_s & ~trig_q;
endmodule

// File: rtl/ring_wr_cntrl.sv
// ring_wr_cntrl -- ring buffer write controller for a triggered ADC capture.
// Fills the ring once (full pre-trigger history), arms, waits for a trigger
// edge, writes a programmable number of post-trigger samples, then freezes
// the write address and requests readout until the readout side finishes.
// Build option: RING_TRIG_SYNC_EN (see trig_edge) synchronizes trig_i.
// Ports:
//   sysclk     : system clock (rising edge)
//   rst_n      : asynchronous active-low reset
//   adc_valid  : ADC sample strobe
//   trig_i     : trigger level
//   posttrig_i : post-trigger sample count (0 selects POST_DEFAULT)
//   ro_done_n  : low when readout controller is finished
//   wr_en      : ring RAM write enable (targets current ain)
//   ain        : write address, frozen during readout
//   rd_request : readout request, registered
//   armed      : high while a trigger edge will be accepted
module ring_wr_cntrl
  import mmaps_pkg::*;
#(
  parameter int          SIZE         = SIZE_DEFAULT,
  parameter int unsigned POST_DEFAULT = 12'h200
) (
  input  logic            sysclk,
  input  logic            rst_n,
  input  logic            adc_valid,
  input  logic            trig_i,
  input  logic [SIZE-1:0] posttrig_i,
  input  logic            ro_done_n,
  output logic            wr_en,
  output logic [SIZE-1:0] ain,
  output logic            rd_request,
  output logic            armed
);
  localparam logic [SIZE-1:0] POST_LOAD = SIZE'(POST_DEFAULT);

  ring_state_t     state;
  logic [SIZE-1:0] fill_cnt;
  logic [SIZE-1:0] post_cnt;
  logic [1:0]      ro_cnt;
  logic            trig_rise;
  logic            write_phase;

  trig_edge u_trig_edge (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .trig_i (trig_i),
    .rise   (trig_rise)
  );

  assign write_phase = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST);
  assign wr_en       = adc_valid & write_phase;
  assign armed       = (state == ST_ARMED);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FILL;
      ain        <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      ro_cnt     <= '0;
      rd_request <= 1'b0;
    end else begin
      if (wr_en) ain <= ain + 1'b1;

      case (state)
        ST_FILL: begin
          // fill_cnt all-ones on a write means this is write number 2**SIZE.
          if (wr_en) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == '1) state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          // A sample coinciding with the edge is written here, as pre-trigger.
          if (trig_rise) begin
            post_cnt <= (posttrig_i == '0) ? POST_LOAD : posttrig_i;
            state    <= ST_POST;
          end
        end
        ST_POST: begin
          // Leave on the write that takes the counter to zero, so no extra
          // sample is written while the counter sits at zero.
          if (post_cnt == '0) begin
            state      <= ST_READOUT;
            rd_request <= 1'b1;
            ro_cnt     <= '0;
          end else if (wr_en) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == SIZE'(1)) begin
              state      <= ST_READOUT;
              rd_request <= 1'b1;
              ro_cnt     <= '0;
            end
          end
        end
        ST_READOUT: begin
          // First two cycles cover downstream pipeline latency.
          if (ro_cnt != 2'd2) begin
            ro_cnt <= ro_cnt + 1'b1;
          end else if (!ro_done_n) begin
            state      <= ST_REARM;
            rd_request <= 1'b0;
          end
        end
        ST_REARM: begin
          fill_cnt <= '0;
          state    <= ST_FILL;
        end
        default: state <= ST_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_ring_wr_cntrl.sv
module tb_ring_wr_cntrl;
  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        adc_valid;
  logic        trig_i;
  logic [11:0] posttrig_i;
  logic        ro_done_n;
  logic        wr_en;
  logic [11:0] ain;
  logic        rd_request;
  logic        armed;

  int vectors    = 0;
  int miscompares = 0;

  ring_wr_cntrl dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .adc_valid  (adc_valid),
    .trig_i     (trig_i),
    .posttrig_i (posttrig_i),
    .ro_done_n  (ro_done_n),
    .wr_en      (wr_en),
    .ain        (ain),
    .rd_request (rd_request),
    .armed      (armed)
  );

  always #5 sysclk = ~sysclk;

  // Advance to 1 ns after the next falling edge; inputs change here.
  task automatic tick;
    @(negedge sysclk);
    #1;
  endtask

  // Stream samples in FILL until armed; n = writes seen. Optional trigger
  // activity during the fill: pulse at 1000..1009, held high from 2000 on.
  task automatic do_fill(input bit poke_trig, output int n);
    n = 0;
    adc_valid = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      #1;
      if (armed) break;
      if (wr_en) n++;
      if (poke_trig) begin
        if (n == 1000) trig_i = 1'b1;
        if (n == 1010) trig_i = 1'b0;
        if (n == 2000) trig_i = 1'b1;
      end
      tick();
    end
    adc_valid = 1'b0;
    vectors++;
    if (armed !== 1'b1) begin
      miscompares++; $display("FAIL fill_timeout: armed=%b required 1", armed);
    end
  endtask

  // Stream samples in POST until rd_request; n = writes seen.
  task automatic count_post(output int n);
    n = 0;
    adc_valid = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      #1;
      if (rd_request) break;
      if (wr_en) n++;
      tick();
    end
    vectors++;
    if (rd_request !== 1'b1) begin
      miscompares++; $display("FAIL post_timeout: rd_request=%b required 1", rd_request);
    end
  endtask

  task automatic fire_trigger(input logic [11:0] pt, input logic v);
    trig_i = 1'b1; posttrig_i = pt; adc_valid = v;
    #1;
    vectors++;
    if (wr_en !== v) begin
      miscompares++; $display("FAIL trig_wr_en: wr_en=%b required %b", wr_en, v);
    end
    tick();
    trig_i = 1'b0; adc_valid = 1'b0;
    vectors++;
    if (armed !== 1'b0) begin
      miscompares++; $display("FAIL trig_accept: armed=%b required 0", armed);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; adc_valid = 1'b0; trig_i = 1'b0; posttrig_i = '0; ro_done_n = 1'b1;
    repeat (3) tick();
    vectors++;
    if (ain !== 12'd0 || rd_request !== 1'b0 || armed !== 1'b0 || wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ain=%0d rd=%b armed=%b wr_en=%b required 0 0 0 0",
               ain, rd_request, armed, wr_en);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill;
    int n;
    do_fill(1'b0, n);
    vectors++;
    if (n !== 4096) begin
      miscompares++; $display("FAIL fill_count: writes=%0d required 4096", n);
    end
    vectors++;
    if (ain !== 12'd0) begin
      miscompares++; $display("FAIL fill_ain: ain=%0d required 0", ain);
    end
  endtask

  // armed at ain=0 -> 100 pre-trigger writes -> trigger, posttrig 10 ->
  // READOUT at 110; ro_done_n low in cycles 1-2 ignored, low at cycle 5.
  task automatic test_trigger_readout;
    int n;
    adc_valid = 1'b1;
    repeat (100) tick();
    adc_valid = 1'b0;
    vectors++;
    if (ain !== 12'd100 || armed !== 1'b1) begin
      miscompares++; $display("FAIL pre_writes: ain=%0d armed=%b required 100 1", ain, armed);
    end
    fire_trigger(12'd10, 1'b0);
    count_post(n);
    vectors++;
    if (n !== 10) begin
      miscompares++; $display("FAIL post_count: writes=%0d required 10", n);
    end
    // READOUT cycle 1 (adc_valid still high)
    vectors++;
    if (ain !== 12'd110 || wr_en !== 1'b0) begin
      miscompares++; $display("FAIL ro_c1: ain=%0d wr_en=%b required 110 0", ain, wr_en);
    end
    ro_done_n = 1'b0;
    tick();
    vectors++;
    if (rd_request !== 1'b1 || ain !== 12'd110) begin
      miscompares++; $display("FAIL ro_c2: rd=%b ain=%0d required 1 110", rd_request, ain);
    end
    tick();
    vectors++;
    if (rd_request !== 1'b1) begin
      miscompares++; $display("FAIL ro_ignore: rd=%b required 1 at cycle 3", rd_request);
    end
    ro_done_n = 1'b1;
    tick();
    vectors++;
    if (rd_request !== 1'b1 || ain !== 12'd110) begin
      miscompares++; $display("FAIL ro_c4: rd=%b ain=%0d required 1 110", rd_request, ain);
    end
    tick();
    vectors++;
    if (rd_request !== 1'b1) begin
      miscompares++; $display("FAIL ro_c5: rd=%b required 1", rd_request);
    end
    ro_done_n = 1'b0;
    tick();
    ro_done_n = 1'b1;
    #1;
    vectors++;
    if (rd_request !== 1'b0 || wr_en !== 1'b0 || armed !== 1'b0 || ain !== 12'd110) begin
      miscompares++;
      $display("FAIL rearm: rd=%b wr_en=%b armed=%b ain=%0d required 0 0 0 110",
               rd_request, wr_en, armed, ain);
    end
    tick();
    #1;
    vectors++;
    if (wr_en !== 1'b1 || rd_request !== 1'b0) begin
      miscompares++; $display("FAIL back_to_fill: wr_en=%b rd=%b required 1 0", wr_en, rd_request);
    end
  endtask

  // Refill with trigger edges during FILL (ignored), trig high on entry to
  // ARMED (no edge), then posttrig 0 -> 512 writes.
  task automatic test_default_post;
    int n;
    do_fill(1'b1, n);
    vectors++;
    if (n !== 4096 || ain !== 12'd110) begin
      miscompares++; $display("FAIL refill: writes=%0d ain=%0d required 4096 110", n, ain);
    end
    repeat (3) tick();
    vectors++;
    if (armed !== 1'b1) begin
      miscompares++; $display("FAIL level_not_edge: armed=%b required 1", armed);
    end
    trig_i = 1'b0;
    tick();
    fire_trigger(12'd0, 1'b0);
    count_post(n);
    vectors++;
    if (n !== 512 || ain !== 12'd622) begin
      miscompares++; $display("FAIL default_post: writes=%0d ain=%0d required 512 622", n, ain);
    end
    // ro_done_n low from cycle 1: leave at end of cycle 3
    ro_done_n = 1'b0;
    tick();
    tick();
    vectors++;
    if (rd_request !== 1'b1) begin
      miscompares++; $display("FAIL ro_hold3: rd=%b required 1", rd_request);
    end
    tick();
    ro_done_n = 1'b1;
    vectors++;
    if (rd_request !== 1'b0) begin
      miscompares++; $display("FAIL ro_exit: rd=%b required 0", rd_request);
    end
    tick();
  endtask

  // ain 4089, trigger coinciding with a sample (pre-trigger write) -> 4090,
  // then 10 writes wrap to 4; reset mid-READOUT drops outputs asynchronously.
  task automatic test_wrap_and_abort;
    int n;
    do_fill(1'b0, n);
    vectors++;
    if (ain !== 12'd622) begin
      miscompares++; $display("FAIL refill2: ain=%0d required 622", ain);
    end
    adc_valid = 1'b1;
    repeat (3467) tick();
    adc_valid = 1'b0;
    vectors++;
    if (ain !== 12'd4089) begin
      miscompares++; $display("FAIL pre_wrap: ain=%0d required 4089", ain);
    end
    fire_trigger(12'd10, 1'b1);
    vectors++;
    if (ain !== 12'd4090) begin
      miscompares++; $display("FAIL coincident: ain=%0d required 4090", ain);
    end
    count_post(n);
    vectors++;
    if (n !== 10 || ain !== 12'd4) begin
      miscompares++; $display("FAIL wrap: writes=%0d ain=%0d required 10 4", n, ain);
    end
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rd_request !== 1'b0 || ain !== 12'd0 || armed !== 1'b0) begin
      miscompares++;
      $display("FAIL async_abort: rd=%b ain=%0d armed=%b required 0 0 0", rd_request, ain, armed);
    end
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    vectors++;
    if (wr_en !== 1'b1 || armed !== 1'b0 || rd_request !== 1'b0) begin
      miscompares++;
      $display("FAIL post_abort: wr_en=%b armed=%b rd=%b required 1 0 0", wr_en, armed, rd_request);
    end
    adc_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_trigger_readout();
    test_default_post();
    test_wrap_and_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ring_wr_cntrl.md
RING_WR_CNTRL -- requirements
Module: ring_wr_cntrl

Interface
REQ-001 SHALL have parameter SIZE, default 12: ring buffer address width, depth 2**SIZE.
REQ-002 SHALL have parameter POST_DEFAULT, default 12'h200: post-trigger sample count used when posttrig_i is 0.
REQ-003 SHALL have port sysclk  in  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port adc_valid  in  1  one-cycle strobe, ADC sample present.
REQ-006 SHALL have port trig_i  in  1  trigger level input.
REQ-007 SHALL have port posttrig_i  in  SIZE  samples to write after trigger; sampled at trigger acceptance.
REQ-008 SHALL have port ro_done_n  in  1  low = readout controller finished.
REQ-009 SHALL have port wr_en  out  1  ring RAM write enable.
REQ-010 SHALL have port ain  out  SIZE  current write address; frozen during readout.
REQ-011 SHALL have port rd_request  out  1  readout request to the address controller.
REQ-012 SHALL have port armed  out  1  high when a trigger will be accepted.

Function
REQ-013 SHALL implement states FILL, ARMED, POST, READOUT, REARM.
REQ-014 SHALL assert wr_en combinationally equal to adc_valid in FILL, ARMED and POST; 0 in READOUT and REARM.
REQ-015 SHALL increment ain by 1 modulo 2**SIZE on each cycle wr_en is high (4095 -> 0), with the RAM write targeting the pre-increment value.
REQ-016 SHALL in FILL count written samples; after 2**SIZE writes go to ARMED, so that a full pre-trigger history is always present.
REQ-017 SHALL accept a trigger only in ARMED, on a rising edge of trig_i; trig_i high on entry to ARMED is not an edge.
REQ-018 SHALL on acceptance load a post counter with posttrig_i, or POST_DEFAULT if posttrig_i == 0, and enter POST.
REQ-019 SHALL in POST decrement the counter on each wr_en; when the counter reaches 0, enter READOUT the next cycle.
REQ-020 SHALL if trigger edge and adc_valid coincide in ARMED, write that sample as a pre-trigger sample; it does not decrement the counter.
REQ-021 SHALL drive rd_request high for the whole of READOUT, registered, with ain stable.
REQ-022 SHALL ignore ro_done_n for the first 2 READOUT cycles (downstream pipeline latency), then leave READOUT on the first cycle ro_done_n == 0.
REQ-023 SHALL hold REARM for exactly 1 cycle with rd_request low, then return to FILL with the fill counter cleared.
REQ-024 SHALL drive armed = 1 only in ARMED.
REQ-025 SHALL ignore trigger edges in FILL, POST, READOUT and REARM, without queueing them.

Reset
REQ-026 SHALL on rst_n low, immediately and independent of sysclk, set state FILL, ain 0, fill and post counters 0, rd_request 0, armed 0, and edge-detect history 1.
REQ-027 SHALL abort any operation when reset is asserted mid-POST or mid-READOUT, with rd_request dropping asynchronously.

Configuration
REQ-028 SHALL with macro RING_TRIG_SYNC_EN defined pass trig_i through a 2-flop synchronizer before edge detection, adding 2 cycles of trigger latency.
REQ-029 SHALL with RING_TRIG_SYNC_EN undefined edge-detect trig_i directly, for a trigger that is already synchronous to sysclk.

Structure
REQ-030 SHALL take the state enum type and the SIZE default constant from shared package mmaps_pkg.
REQ-031 SHALL contain one sub-module, trig_edge, holding the optional synchronizer and rising-edge detector.

Verification
REQ-032 SHALL cover: reset, then adc_valid every cycle -> armed rises after 4096 writes, ain == 0.
REQ-033 SHALL cover: armed, ain=100, posttrig_i=10, trig edge -> 10 further writes, READOUT with ain=110 frozen, rd_request=1.
REQ-034 SHALL cover: posttrig_i=0 -> exactly 512 (POST_DEFAULT) post-trigger writes.
REQ-035 SHALL cover: ain=4090, posttrig_i=10 -> ain wraps, READOUT at ain=4.
REQ-036 SHALL cover: ro_done_n low during the first 2 READOUT cycles -> ignored; ro_done_n low at cycle 5 -> REARM 1 cycle, then FILL.
REQ-037 SHALL cover: rst_n pulse mid-READOUT -> rd_request=0 and ain=0 asynchronously; trig edge during FILL -> no capture.
